// File: rtl/gdev_vid_pkg.sv
// Shared video-path definitions: fetch FSM states and pixel/line geometry
// common to the scanline fetch controller, SCANLINE and the mixer.
package gdev_vid_pkg;

  localparam int RGB_W        = 15;
  localparam int DEF_LINE_PIX = 640;
  localparam int DEF_LINES    = 480;
  localparam int AVL_BC_W     = 7;

  typedef enum logic [1:0] {
    IDLE,
    START,
    REQ,
    DATA
  } fetch_state_t;

  // Column counters must also hold BURST (up to 64) for the min() compare.
  function automatic int cnt_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w > AVL_BC_W) ? w : AVL_BC_W;
  endfunction

endpackage

// File: rtl/fetch_addr_gen.sv
// Line/column position tracking for the scanline fetcher: frame reload,
// line advance, burst address and burst length generation.
module fetch_addr_gen
  import gdev_vid_pkg::*;
#(
  parameter int ADDR_W   = 22,
  parameter int LINE_PIX = DEF_LINE_PIX,
  parameter int LINES    = DEF_LINES,
  parameter int BURST    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic [ADDR_W-1:0]   fb_base,
  input  logic                idle,
  input  logic                line_start,
  input  logic                burst_done,
  output logic [ADDR_W-1:0]   addr,
  output logic [AVL_BC_W-1:0] burstcount,
  output logic                last_burst,
  output logic                line_ok
);

  localparam int COL_W  = cnt_width(LINE_PIX);
  localparam int LINE_W = $clog2(LINES + 1);
  localparam logic [COL_W-1:0]  LINE_PIX_C = COL_W'(LINE_PIX);
  localparam logic [COL_W-1:0]  BURST_C    = COL_W'(BURST);
  localparam logic [LINE_W-1:0] LINES_C    = LINE_W'(LINES);

  logic [LINE_W-1:0] line;
  logic [ADDR_W-1:0] line_base;
  logic [ADDR_W-1:0] pend_base;
  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  remaining;
  logic [COL_W-1:0]  step;
  logic              pend;
  logic              reload;

  // A frame reload only lands while idle, so a line in flight keeps its addresses.
  always_comb begin
    reload     = idle && (frame_start || pend);
    remaining  = LINE_PIX_C - col;
    step       = (remaining > BURST_C) ? BURST_C : remaining;
    last_burst = (step == remaining);
    burstcount = AVL_BC_W'(step);
    addr       = line_base + ADDR_W'(col);
    line_ok    = reload || (line < LINES_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line      <= '0;
      line_base <= '0;
      pend_base <= '0;
      pend      <= 1'b0;
      col       <= '0;
    end else begin
      if (reload) begin
        line      <= '0;
        line_base <= frame_start ? fb_base : pend_base;
        pend      <= 1'b0;
      end else if (frame_start) begin
        pend      <= 1'b1;
        pend_base <= fb_base;
      end

      if (line_start) begin
        col <= '0;
      end else if (burst_done) begin
        col <= col + step;
        if (last_burst) begin
          line      <= line + LINE_W'(1);
          line_base <= line_base + ADDR_W'(LINE_PIX);
        end
      end
    end
  end

endmodule

// File: rtl/scanline_fetch_ctrl.sv
// Framebuffer line-fetch sequencer: one Avalon-MM read burst in flight at a
// time, streaming RGB555 pixels into the SCANLINE write port.
module scanline_fetch_ctrl
  import gdev_vid_pkg::*;
#(
  parameter int ADDR_W   = 22,
  parameter int LINE_PIX = DEF_LINE_PIX,
  parameter int LINES    = DEF_LINES,
  parameter int BURST    = 8
) (
  input  logic                iCLK,
  input  logic                iRESET,
  input  logic                iENABLE,
  input  logic [ADDR_W-1:0]   iFB_BASE,
  input  logic                iFRAME_START,
  input  logic                iLINE_REQ,
  output logic [ADDR_W-1:0]   oAVL_ADDRESS,
  output logic                oAVL_READ,
  output logic [AVL_BC_W-1:0] oAVL_BURSTCOUNT,
  input  logic                iAVL_WAITREQUEST,
  input  logic [15:0]         iAVL_READDATA,
  input  logic                iAVL_READDATAVALID,
  output logic                oPIX_START,
  output logic                oPIX_WRITE,
  output logic [RGB_W-1:0]    oPIX_RGB,
  input  logic                iPIX_FULL,
  output logic                oBUSY,
  output logic                oOVERRUN
);

  fetch_state_t        state;
  logic [AVL_BC_W-1:0] beats;
  logic [ADDR_W-1:0]   gen_addr;
  logic [AVL_BC_W-1:0] gen_bc;
  logic                last_burst;
  logic                line_ok;
  logic                line_start;
  logic                burst_done;
  logic                issue;
  logic                unused_msb;

  assign unused_msb = iAVL_READDATA[15];

  fetch_addr_gen #(
    .ADDR_W   (ADDR_W),
    .LINE_PIX (LINE_PIX),
    .LINES    (LINES),
    .BURST    (BURST)
  ) u_addr_gen (
    .clk         (iCLK),
    .reset       (iRESET),
    .frame_start (iFRAME_START),
    .fb_base     (iFB_BASE),
    .idle        (state == IDLE),
    .line_start  (line_start),
    .burst_done  (burst_done),
    .addr        (gen_addr),
    .burstcount  (gen_bc),
    .last_burst  (last_burst),
    .line_ok     (line_ok)
  );

  // Reads may launch straight from START so the first request lands two cycles after the line request.
  always_comb begin
    line_start = (state == IDLE) && iLINE_REQ && iENABLE && line_ok;
    burst_done = (state == DATA) && iAVL_READDATAVALID && (beats == AVL_BC_W'(1));
    issue      = !iPIX_FULL && ((state == START) || ((state == REQ) && !oAVL_READ));
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state           <= IDLE;
      beats           <= '0;
      oAVL_ADDRESS    <= '0;
      oAVL_READ       <= 1'b0;
      oAVL_BURSTCOUNT <= '0;
      oPIX_START      <= 1'b0;
      oPIX_WRITE      <= 1'b0;
      oPIX_RGB        <= '0;
      oBUSY           <= 1'b0;
      oOVERRUN        <= 1'b0;
    end else begin
      oPIX_START <= 1'b0;
      oPIX_WRITE <= 1'b0;
      oOVERRUN   <= iLINE_REQ && (state != IDLE);

      if (issue) begin
        oAVL_READ       <= 1'b1;
        oAVL_ADDRESS    <= gen_addr;
        oAVL_BURSTCOUNT <= gen_bc;
      end

      case (state)
        IDLE: begin
          if (line_start) begin
            state      <= START;
            oPIX_START <= 1'b1;
            oBUSY      <= 1'b1;
          end
        end
        START: state <= REQ;
        REQ: begin
          if (oAVL_READ && !iAVL_WAITREQUEST) begin
            oAVL_READ <= 1'b0;
            beats     <= oAVL_BURSTCOUNT;
            state     <= DATA;
          end
        end
        DATA: begin
          if (iAVL_READDATAVALID) begin
            oPIX_WRITE <= 1'b1;
            oPIX_RGB   <= iAVL_READDATA[RGB_W-1:0];
            beats      <= beats - AVL_BC_W'(1);
            if (beats == AVL_BC_W'(1)) begin
              state <= last_burst ? IDLE : REQ;
              oBUSY <= !last_burst;
            end
          end
        end
        default: begin
          state <= IDLE;
          oBUSY <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scanline_fetch_ctrl.sv
// Directed bench: a full-size fetcher (640x480) and a small one (20x4) share
// one Avalon memory model whose read data is the word address with bit 15 set.
module tb_scanline_fetch_ctrl;

  typedef struct {
    string       name;
    int          g;
    bit          en;
    bit          fs;
    logic [21:0] base;
    int          n;
    logic [21:0] first;
    logic [21:0] last;
    int          bc0;
    int          bcl;
    int          writes;
    int          starts;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        en[2], fs[2], lreq[2], waitreq[2], rdv[2], full[2];
  logic [21:0] base[2], addr[2], nxt[2];
  logic        read[2], pstart[2], pwrite[2], busy[2], ovr[2];
  logic [6:0]  bc[2];
  logic [15:0] rdata[2];
  logic [14:0] prgb[2];
  int          stall_len[2], stall_seen[2], pend[2];

  int          acc_n[2], wr_n[2], start_n[2], ovr_n[2], rgb_bad[2];
  logic [21:0] acc_addr[2][512];
  logic [6:0]  acc_bc[2][512];
  logic [14:0] pix_q[2][$];

  int          checks = 0;
  int          errors = 0;
  vec_t        vecs[9];

  always #5 clk = ~clk;

  assign waitreq[0] = stall_seen[0] < stall_len[0];
  assign waitreq[1] = stall_seen[1] < stall_len[1];

  scanline_fetch_ctrl #(.ADDR_W(22), .LINE_PIX(640), .LINES(480), .BURST(8)) u_big (
    .iCLK(clk), .iRESET(reset), .iENABLE(en[0]), .iFB_BASE(base[0]),
    .iFRAME_START(fs[0]), .iLINE_REQ(lreq[0]), .oAVL_ADDRESS(addr[0]),
    .oAVL_READ(read[0]), .oAVL_BURSTCOUNT(bc[0]), .iAVL_WAITREQUEST(waitreq[0]),
    .iAVL_READDATA(rdata[0]), .iAVL_READDATAVALID(rdv[0]), .oPIX_START(pstart[0]),
    .oPIX_WRITE(pwrite[0]), .oPIX_RGB(prgb[0]), .iPIX_FULL(full[0]),
    .oBUSY(busy[0]), .oOVERRUN(ovr[0]));

  scanline_fetch_ctrl #(.ADDR_W(22), .LINE_PIX(20), .LINES(4), .BURST(8)) u_small (
    .iCLK(clk), .iRESET(reset), .iENABLE(en[1]), .iFB_BASE(base[1]),
    .iFRAME_START(fs[1]), .iLINE_REQ(lreq[1]), .oAVL_ADDRESS(addr[1]),
    .oAVL_READ(read[1]), .oAVL_BURSTCOUNT(bc[1]), .iAVL_WAITREQUEST(waitreq[1]),
    .iAVL_READDATA(rdata[1]), .iAVL_READDATAVALID(rdv[1]), .oPIX_START(pstart[1]),
    .oPIX_WRITE(pwrite[1]), .oPIX_RGB(prgb[1]), .iPIX_FULL(full[1]),
    .oBUSY(busy[1]), .oOVERRUN(ovr[1]));

  // Memory model: returns the accepted burst one beat per cycle after acceptance.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      rdv[g] <= 1'b0;
      if (reset) begin
        pend[g]       <= 0;
        stall_seen[g] <= 0;
      end else if (read[g] && waitreq[g]) begin
        stall_seen[g] <= stall_seen[g] + 1;
      end else if (read[g]) begin
        pend[g]       <= int'(bc[g]);
        nxt[g]        <= addr[g];
        stall_seen[g] <= 0;
      end else if (pend[g] != 0) begin
        rdv[g]   <= 1'b1;
        rdata[g] <= {1'b1, nxt[g][14:0]};
        nxt[g]   <= nxt[g] + 22'd1;
        pend[g]  <= pend[g] - 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        pix_q[g].delete();
      end else begin
        if (read[g] && !waitreq[g]) begin
          acc_addr[g][acc_n[g] % 512] = addr[g];
          acc_bc[g][acc_n[g] % 512]   = bc[g];
          acc_n[g]++;
          for (int i = 0; i < int'(bc[g]); i++) pix_q[g].push_back(15'(addr[g] + 22'(i)));
        end
        if (pwrite[g]) begin
          wr_n[g]++;
          if (pix_q[g].size() == 0) rgb_bad[g]++;
          else if (prgb[g] != pix_q[g].pop_front()) rgb_bad[g]++;
        end
        if (pstart[g]) start_n[g]++;
        if (ovr[g]) ovr_n[g]++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkZero(input string name, input int g);
    checkOutput({name, "_addr"}, 32'(addr[g]), 0);
    checkOutput({name, "_ctl"}, {20'd0, read[g], pstart[g], pwrite[g], busy[g], ovr[g], bc[g]}, 0);
    checkOutput({name, "_rgb"}, 32'(prgb[g]), 0);
  endtask

  task automatic waitIdle(input int g);
    int k = 0;
    while (busy[g] && k < 4000) begin
      @(negedge clk);
      k++;
    end
    checkOutput("idle_timeout", 32'(busy[g]), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    int a0, w0, s0, r0, o0;
    a0 = acc_n[v.g]; w0 = wr_n[v.g]; s0 = start_n[v.g]; r0 = rgb_bad[v.g]; o0 = ovr_n[v.g];
    @(negedge clk);
    en[v.g] = v.en; base[v.g] = v.base; fs[v.g] = v.fs; lreq[v.g] = 1'b1;
    @(negedge clk);
    fs[v.g] = 1'b0; lreq[v.g] = 1'b0; en[v.g] = 1'b1;
    waitIdle(v.g);
    checkOutput({v.name, "_bursts"}, acc_n[v.g] - a0, v.n);
    checkOutput({v.name, "_writes"}, wr_n[v.g] - w0, v.writes);
    checkOutput({v.name, "_starts"}, start_n[v.g] - s0, v.starts);
    checkOutput({v.name, "_rgb"}, rgb_bad[v.g] - r0, 0);
    checkOutput({v.name, "_ovr"}, ovr_n[v.g] - o0, 0);
    if (v.n > 0) begin
      checkOutput({v.name, "_first_addr"}, 32'(acc_addr[v.g][a0 % 512]), 32'(v.first));
      checkOutput({v.name, "_last_addr"}, 32'(acc_addr[v.g][(a0 + v.n - 1) % 512]), 32'(v.last));
      checkOutput({v.name, "_first_bc"}, 32'(acc_bc[v.g][a0 % 512]), v.bc0);
      checkOutput({v.name, "_last_bc"}, 32'(acc_bc[v.g][(a0 + v.n - 1) % 512]), v.bcl);
    end
  endtask

  initial begin
    int a0, s0, w0, o0, r0, bad, k;
    logic [21:0] hold_addr;
    logic [6:0]  hold_bc;

    vecs[0] = '{"big_l0", 0, 1'b1, 1'b1, 22'h1000, 80, 22'h1000, 22'h1278, 8, 8, 640, 1};
    vecs[1] = '{"big_l1", 0, 1'b1, 1'b0, 22'h0,    80, 22'h1280, 22'h14F8, 8, 8, 640, 1};
    vecs[2] = '{"sm_l0",  1, 1'b1, 1'b1, 22'h0100, 3, 22'h0100, 22'h0110, 8, 4, 20, 1};
    vecs[3] = '{"sm_l1",  1, 1'b1, 1'b0, 22'h0,    3, 22'h0114, 22'h0124, 8, 4, 20, 1};
    vecs[4] = '{"sm_l2",  1, 1'b1, 1'b0, 22'h0,    3, 22'h0128, 22'h0138, 8, 4, 20, 1};
    vecs[5] = '{"sm_l3",  1, 1'b1, 1'b0, 22'h0,    3, 22'h013C, 22'h014C, 8, 4, 20, 1};
    vecs[6] = '{"sm_end", 1, 1'b1, 1'b0, 22'h0,    0, 22'h0,    22'h0,    0, 0, 0, 0};
    vecs[7] = '{"sm_fs",  1, 1'b1, 1'b1, 22'h2000, 3, 22'h2000, 22'h2010, 8, 4, 20, 1};
    vecs[8] = '{"sm_dis", 1, 1'b0, 1'b0, 22'h0,    0, 22'h0,    22'h0,    0, 0, 0, 0};

    reset = 1'b1;
    for (int g = 0; g < 2; g++) begin
      en[g] = 1'b1; fs[g] = 1'b0; lreq[g] = 1'b0; full[g] = 1'b0;
      base[g] = '0; stall_len[g] = 0;
    end
    repeat (3) @(negedge clk);
    checkZero("reset_big", 0);
    checkZero("reset_small", 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

    // Stalled first burst on small line 1 (0x2014), also pins request latency.
    a0 = acc_n[1];
    stall_len[1] = 5;
    lreq[1] = 1'b1;
    @(negedge clk);
    lreq[1] = 1'b0;
    checkOutput("lat_start", 32'(pstart[1]), 1);
    @(negedge clk);
    checkOutput("lat_read", 32'(read[1]), 1);
    checkOutput("lat_addr", 32'(addr[1]), 32'h2014);
    hold_addr = addr[1];
    hold_bc = bc[1];
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!(read[1] && waitreq[1] && addr[1] == hold_addr && bc[1] == hold_bc)) bad++;
      @(negedge clk);
    end
    checkOutput("stall_stable", bad, 0);
    checkOutput("stall_release", {30'd0, read[1], waitreq[1]}, 2);
    @(negedge clk);
    checkOutput("stall_one_accept", acc_n[1] - a0, 1);
    checkOutput("stall_read_drop", 32'(read[1]), 0);
    stall_len[1] = 0;
    waitIdle(1);
    checkOutput("stall_line_bursts", acc_n[1] - a0, 3);

    // SCANLINE full before the first request of line 2 (0x2028).
    full[1] = 1'b1;
    lreq[1] = 1'b1;
    @(negedge clk);
    lreq[1] = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (read[1]) bad++;
    end
    checkOutput("full_no_read", bad, 0);
    checkOutput("full_busy", 32'(busy[1]), 1);
    full[1] = 1'b0;
    @(negedge clk);
    checkOutput("full_read_next", 32'(read[1]), 1);
    checkOutput("full_addr", 32'(addr[1]), 32'h2028);
    waitIdle(1);

    // Line request during DATA on line 3 (0x203C) is dropped with one overrun pulse.
    a0 = acc_n[1]; s0 = start_n[1]; w0 = wr_n[1]; o0 = ovr_n[1]; r0 = rgb_bad[1];
    lreq[1] = 1'b1;
    @(negedge clk);
    lreq[1] = 1'b0;
    k = 0;
    while (!pwrite[1] && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("ovr_wait_write", 32'(pwrite[1]), 1);
    lreq[1] = 1'b1;
    @(negedge clk);
    lreq[1] = 1'b0;
    checkOutput("ovr_pulse", 32'(ovr[1]), 1);
    @(negedge clk);
    checkOutput("ovr_single", 32'(ovr[1]), 0);
    waitIdle(1);
    repeat (10) @(negedge clk);
    checkOutput("ovr_bursts", acc_n[1] - a0, 3);
    checkOutput("ovr_first_addr", 32'(acc_addr[1][a0 % 512]), 32'h203C);
    checkOutput("ovr_starts", start_n[1] - s0, 1);
    checkOutput("ovr_writes", wr_n[1] - w0, 20);
    checkOutput("ovr_count", ovr_n[1] - o0, 1);
    checkOutput("ovr_rgb", rgb_bad[1] - r0, 0);
    checkOutput("ovr_idle", 32'(busy[1]), 0);

    // Reset in the middle of a big-line burst, then fetch from the reset base.
    lreq[0] = 1'b1;
    @(negedge clk);
    lreq[0] = 1'b0;
    k = 0;
    while (!pwrite[0] && k < 100) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rst_wait_write", 32'(pwrite[0]), 1);
    reset = 1'b1;
    @(negedge clk);
    checkZero("midrst_big", 0);
    checkZero("midrst_small", 1);
    reset = 1'b0;
    @(negedge clk);
    lreq[0] = 1'b1;
    @(negedge clk);
    lreq[0] = 1'b0;
    k = 0;
    while (!read[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("post_rst_read", 32'(read[0]), 1);
    checkOutput("post_rst_addr", 32'(addr[0]), 0);
    waitIdle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scanline_fetch_ctrl.md
# scanline_fetch_ctrl

Framebuffer line-fetch sequencer in the memory-clock domain. Per line request, reads one scanline of 15-bit RGB pixels from SDRAM over an Avalon-MM burst master and streams them into the SCANLINE buffer's pixel-write port. It tracks line/frame position, generates burst addresses incrementally, and throttles on the buffer's full flag. It replaces ad-hoc pixel pushing by the video mixer with a deterministic, one-burst-in-flight schedule.

## Interface
Parameters:
- ADDR_W, 22, Avalon word-address width
- LINE_PIX, 640, pixels (16-bit words) per line
- LINES, 480, lines per frame
- BURST, 8, maximum burstcount; power of two, 1..64

Ports:
- iCLK  in  1  memory clock; single clock for the whole block
- iRESET  in  1  synchronous, active-high reset
- iENABLE  in  1  fetch enable; sampled at line start only
- iFB_BASE  in  ADDR_W  framebuffer word base; sampled at frame start
- iFRAME_START  in  1  one-cycle pulse, frame begins (already synchronized)
- iLINE_REQ  in  1  one-cycle pulse, fetch next line (already synchronized)
- oAVL_ADDRESS  out  ADDR_W  burst start word address
- oAVL_READ  out  1  read request
- oAVL_BURSTCOUNT  out  7  beats in this burst
- iAVL_WAITREQUEST  in  1  slave stall
- iAVL_READDATA  in  16  read data; bit 15 ignored
- iAVL_READDATAVALID  in  1  read beat valid
- oPIX_START  out  1  one-cycle pulse, new line to SCANLINE
- oPIX_WRITE  out  1  pixel write strobe
- oPIX_RGB  out  15  pixel data
- iPIX_FULL  in  1  SCANLINE almost-full; asserts with at least BURST free entries
- oBUSY  out  1  line fetch in progress
- oOVERRUN  out  1  one-cycle pulse, line request dropped

## Operation
- States: IDLE, START, REQ, DATA.
- IDLE: on iLINE_REQ with iENABLE=1 and line < LINES: go to START. If iENABLE=0 or line = LINES, the request is ignored silently.
- START: pulse oPIX_START, col=0, then go to REQ.
- REQ: if iPIX_FULL=0, assert oAVL_READ with address = line_base + col and burstcount = min(BURST, LINE_PIX − col). Hold address, read and burstcount unchanged while iAVL_WAITREQUEST=1. On acceptance, deassert read, load beat counter, go to DATA.
- DATA: each iAVL_READDATAVALID writes one pixel, RGB = readdata[14:0]. After the last beat, col += burstcount. If col = LINE_PIX: line += 1, line_base += LINE_PIX, go to IDLE. Otherwise return to REQ.
- Exactly one burst is outstanding at any time. The iPIX_FULL slack guarantees that unstallable beats never overflow SCANLINE.
- iFRAME_START: line=0 and line_base=iFB_BASE. This takes effect at the next IDLE. If a line is in progress, it finishes with the old addresses and the reload is deferred until it completes.
- iLINE_REQ while state ≠ IDLE: the request is dropped and oOVERRUN pulses one cycle.
- If iLINE_REQ and iFRAME_START fire in the same IDLE cycle, the frame reload applies first, so line 0 is fetched.
- Address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
- Burstcount is never 0. A final short burst is issued when LINE_PIX mod BURST ≠ 0.
- oBUSY = (state ≠ IDLE).

## Timing
- Reset values: oAVL_READ=0, oAVL_ADDRESS=0, oAVL_BURSTCOUNT=0, oPIX_START=0, oPIX_WRITE=0, oPIX_RGB=0, oBUSY=0, oOVERRUN=0. Internal values: line=0, line_base=0, col=0, state IDLE.
- iLINE_REQ in cycle N gives oPIX_START in cycle N+1. The earliest oAVL_READ is in cycle N+2.
- oPIX_WRITE/oPIX_RGB are registered: a readdatavalid in cycle M produces a write in cycle M+1.
- The next oAVL_READ can assert at the earliest one cycle after the last beat's write cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Reset mid-burst returns all state to reset values immediately. The Avalon interconnect is reset by the same iRESET, so stale beats never arrive.

## Structure
- Shared package gdev_vid_pkg holds the state enum, the RGB555 pixel width (15), and the default LINE_PIX/LINES constants shared with SCANLINE and the mixer.
- One natural sub-module is fetch_addr_gen: it holds line, line_base and col, handles frame reload and line advance, and computes the burstcount. The FSM and beat counter stay in the top module.

## Test plan
- LINE_PIX=640, BURST=8, base 0x1000, no stalls: line 0 → 80 bursts at 0x1000, 0x1008, …, 0x1278; 640 writes; oPIX_START once; line 1 starts at 0x1280.
- LINE_PIX=20, BURST=8: bursts of 8, 8, 4 at col 0, 8, 16; exactly 20 writes; RGB equals readdata[14:0] with bit 15 set in stimulus.
- iAVL_WAITREQUEST high for 5 cycles: address, read and burstcount stay stable across all 5 cycles; exactly one acceptance.
- iPIX_FULL held 1 in REQ for 10 cycles: no oAVL_READ during those cycles; the read issues one cycle after full drops.
- iLINE_REQ during DATA: oOVERRUN pulses one cycle, the current line completes normally, and no extra line is fetched.
- After 480 lines with LINES=480, iLINE_REQ is ignored. iFRAME_START with base 0x2000, then iLINE_REQ: first address is 0x2000. iRESET asserted mid-burst: all outputs read 0 on the next cycle.
